// File: rtl/regfile_writeback_arbiter.sv
// Register-file write-port arbiter: merges ALU results and FIFO-buffered load results.
// Optional WB_BYPASS_EN adds same-cycle forwarding outputs for the decode stage.
module regfile_writeback_arbiter #(
  parameter int ADDR_SIZE  = 4,
  parameter int DATA_W     = 16,
  parameter int LD_DEPTH   = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [ADDR_SIZE-1:0] alu_addr,
  input  logic [DATA_W-1:0]    alu_data,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [ADDR_SIZE-1:0] ld_addr,
  input  logic [DATA_W-1:0]    ld_data,
  output logic                 w_en,
  output logic [ADDR_SIZE-1:0] addr_c,
  output logic [DATA_W-1:0]    data_c,
  output logic                 busy
`ifdef WB_BYPASS_EN
  ,
  input  logic [ADDR_SIZE-1:0] byp_addr_a,
  input  logic [ADDR_SIZE-1:0] byp_addr_b,
  output logic                 byp_hit_a,
  output logic                 byp_hit_b,
  output logic [DATA_W-1:0]    byp_data
`endif
);

  localparam int PW = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
  localparam int CW = $clog2(LD_DEPTH) + 1;
  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  logic [ADDR_SIZE-1:0] fifo_addr [LD_DEPTH];
  logic [DATA_W-1:0]    fifo_data [LD_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic [SW-1:0]        starve_cnt;

  logic ld_pending, force_ld, grant_ld, grant_alu, push;

  always_comb begin
    ld_pending = (count != '0);
    force_ld   = ld_pending && (starve_cnt == SW'(STARVE_MAX));
    grant_ld   = ld_pending && (force_ld || !alu_valid);
    grant_alu  = alu_valid && !force_ld;
    alu_ready  = !force_ld;
    ld_ready   = (count != CW'(LD_DEPTH));
    push       = ld_valid && ld_ready;
    busy       = ld_pending || w_en;
  end

  // Storage is not reset; the pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= ld_addr;
      fifo_data[wr_ptr] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      w_en       <= 1'b0;
      addr_c     <= '0;
      data_c     <= '0;
    end else begin
      if (push)     wr_ptr <= wr_ptr + PW'(1);
      if (grant_ld) rd_ptr <= rd_ptr + PW'(1);
      case ({push, grant_ld})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      // Starvation is counted only against a load already waiting this cycle.
      if (grant_ld || !ld_pending)
        starve_cnt <= '0;
      else if (grant_alu && starve_cnt != SW'(STARVE_MAX))
        starve_cnt <= starve_cnt + SW'(1);

      if (grant_alu) begin
        w_en   <= 1'b1;
        addr_c <= alu_addr;
        data_c <= alu_data;
      end else if (grant_ld) begin
        w_en   <= 1'b1;
        addr_c <= fifo_addr[rd_ptr];
        data_c <= fifo_data[rd_ptr];
      end else begin
        w_en   <= 1'b0;
      end
    end
  end

`ifdef WB_BYPASS_EN
  always_comb begin
    byp_hit_a = w_en && (addr_c == byp_addr_a);
    byp_hit_b = w_en && (addr_c == byp_addr_b);
    byp_data  = data_c;
  end
`endif

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Bench for regfile_writeback_arbiter: vector table, reset/starvation sequences,
// and a randomized phase checked against per-source expectation queues.
module tb_regfile_writeback_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alu_valid = 1'b0, ld_valid = 1'b0;
  logic        alu_ready, ld_ready, w_en, busy;
  logic [3:0]  alu_addr = '0, ld_addr = '0, addr_c;
  logic [15:0] alu_data = '0, ld_data = '0, data_c;
`ifdef WB_BYPASS_EN
  logic [3:0]  byp_addr_a = '0, byp_addr_b = '0;
  logic        byp_hit_a, byp_hit_b;
  logic [15:0] byp_data;
`endif

  always #5 clk = ~clk;

  regfile_writeback_arbiter #(.ADDR_SIZE(4), .DATA_W(16), .LD_DEPTH(2), .STARVE_MAX(3)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .w_en(w_en), .addr_c(addr_c), .data_c(data_c), .busy(busy)
`ifdef WB_BYPASS_EN
    , .byp_addr_a(byp_addr_a), .byp_addr_b(byp_addr_b),
    .byp_hit_a(byp_hit_a), .byp_hit_b(byp_hit_b), .byp_data(byp_data)
`endif
  );

  // Register file image built from what the write port actually does.
  logic [15:0] rf [16];
  always @(posedge clk) if (w_en) rf[addr_c] <= data_c;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        av; logic [3:0] aa; logic [15:0] ad;
    logic        lv; logic [3:0] la; logic [15:0] ldv;
    logic        ar, lr, wen; logic [3:0] wa; logic [15:0] wd;
  } vec_t;

  function automatic vec_t mk(input logic av, input logic [3:0] aa, input logic [15:0] ad,
                              input logic lv, input logic [3:0] la, input logic [15:0] ldv,
                              input logic ar, input logic lr,
                              input logic wen, input logic [3:0] wa, input logic [15:0] wd);
    vec_t v;
    v.av = av; v.aa = aa; v.ad = ad; v.lv = lv; v.la = la; v.ldv = ldv;
    v.ar = ar; v.lr = lr; v.wen = wen; v.wa = wa; v.wd = wd;
    return v;
  endfunction

  vec_t tbl [17];

  typedef struct { logic [3:0] a; logic [15:0] d; } wr_t;
  wr_t alu_q [$];
  wr_t ld_q  [$];
  int  alu_run = 0;

  task automatic sb_check();
    wr_t e;
    if (!w_en) return;
    if (data_c[15]) begin
      alu_run = 0;
      if (ld_q.size() == 0) begin chk("sb_ld_unexpected", 1, 0); return; end
      e = ld_q.pop_front();
      chk("sb_ld_addr", 32'(addr_c), 32'(e.a));
      chk("sb_ld_data", 32'(data_c), 32'(e.d));
    end else begin
      if (alu_q.size() == 0) begin chk("sb_alu_unexpected", 1, 0); return; end
      e = alu_q.pop_front();
      chk("sb_alu_addr", 32'(addr_c), 32'(e.a));
      chk("sb_alu_data", 32'(data_c), 32'(e.d));
      if (ld_q.size() != 0) begin
        alu_run++;
        chk("sb_starve_bound", 32'(alu_run <= 4), 1);
      end else alu_run = 0;
    end
  endtask

  initial begin
    tbl[0]  = mk(1, 4'h3, 16'hBEEF, 0, 4'h0, 16'h0000, 1, 1, 1, 4'h3, 16'hBEEF);
    tbl[1]  = mk(0, 4'h0, 16'h0000, 0, 4'h0, 16'h0000, 1, 1, 0, 4'h3, 16'hBEEF);
    tbl[2]  = mk(0, 4'h0, 16'h0000, 1, 4'hA, 16'h1234, 1, 1, 0, 4'h3, 16'hBEEF);
    tbl[3]  = mk(0, 4'h0, 16'h0000, 0, 4'h0, 16'h0000, 1, 1, 1, 4'hA, 16'h1234);
    tbl[4]  = mk(1, 4'h8, 16'h0008, 1, 4'h1, 16'h8001, 1, 1, 1, 4'h8, 16'h0008);
    tbl[5]  = mk(1, 4'h9, 16'h0009, 1, 4'h2, 16'h8002, 1, 1, 1, 4'h9, 16'h0009);
    tbl[6]  = mk(1, 4'hA, 16'h000A, 1, 4'h3, 16'h8003, 1, 0, 1, 4'hA, 16'h000A);
    tbl[7]  = mk(1, 4'hB, 16'h000B, 0, 4'h0, 16'h0000, 1, 0, 1, 4'hB, 16'h000B);
    tbl[8]  = mk(1, 4'hC, 16'h000C, 0, 4'h0, 16'h0000, 0, 0, 1, 4'h1, 16'h8001);
    tbl[9]  = mk(1, 4'hC, 16'h000C, 0, 4'h0, 16'h0000, 1, 1, 1, 4'hC, 16'h000C);
    tbl[10] = mk(1, 4'hD, 16'h000D, 0, 4'h0, 16'h0000, 1, 1, 1, 4'hD, 16'h000D);
    tbl[11] = mk(1, 4'hE, 16'h000E, 0, 4'h0, 16'h0000, 1, 1, 1, 4'hE, 16'h000E);
    tbl[12] = mk(1, 4'hF, 16'h000F, 0, 4'h0, 16'h0000, 0, 1, 1, 4'h2, 16'h8002);
    tbl[13] = mk(1, 4'hF, 16'h000F, 0, 4'h0, 16'h0000, 1, 1, 1, 4'hF, 16'h000F);
    tbl[14] = mk(1, 4'h5, 16'h0001, 1, 4'h5, 16'h0002, 1, 1, 1, 4'h5, 16'h0001);
    tbl[15] = mk(0, 4'h0, 16'h0000, 0, 4'h0, 16'h0000, 1, 1, 1, 4'h5, 16'h0002);
    tbl[16] = mk(0, 4'h0, 16'h0000, 0, 4'h0, 16'h0000, 1, 1, 0, 4'h5, 16'h0002);

    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_w_en", 32'(w_en), 0);
    chk("rst_addr_c", 32'(addr_c), 0);
    chk("rst_data_c", 32'(data_c), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ld_ready", 32'(ld_ready), 1);
    chk("rst_alu_ready", 32'(alu_ready), 1);
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed vectors: ALU-only, load latency, FIFO full, starvation, same destination
    for (int i = 0; i < 17; i++) begin
      alu_valid = tbl[i].av; alu_addr = tbl[i].aa; alu_data = tbl[i].ad;
      ld_valid  = tbl[i].lv; ld_addr  = tbl[i].la; ld_data  = tbl[i].ldv;
      #1;
      chk($sformatf("v%0d_alu_ready", i), 32'(alu_ready), 32'(tbl[i].ar));
      chk($sformatf("v%0d_ld_ready", i), 32'(ld_ready), 32'(tbl[i].lr));
      @(posedge clk); #1;
      chk($sformatf("v%0d_w_en", i), 32'(w_en), 32'(tbl[i].wen));
      chk($sformatf("v%0d_addr_c", i), 32'(addr_c), 32'(tbl[i].wa));
      chk($sformatf("v%0d_data_c", i), 32'(data_c), 32'(tbl[i].wd));
`ifdef WB_BYPASS_EN
      if (i == 0) begin
        byp_addr_a = 4'h3; byp_addr_b = 4'h2; #1;
        chk("byp_hit_a", 32'(byp_hit_a), 1);
        chk("byp_hit_b", 32'(byp_hit_b), 0);
        chk("byp_data", 32'(byp_data), 32'h0000BEEF);
      end
`endif
    end
    chk("same_dest_final_r5", 32'(rf[5]), 32'h0002);
    chk("idle_busy", 32'(busy), 0);

    // Mid-stream async reset with two loads queued behind ALU traffic
    alu_valid = 1; alu_addr = 4'h1; alu_data = 16'h0101;
    ld_valid  = 1; ld_addr  = 4'h6; ld_data  = 16'h8006;
    @(posedge clk); #1;
    alu_addr = 4'h2; alu_data = 16'h0102; ld_addr = 4'h7; ld_data = 16'h8007;
    @(posedge clk); #1;
    alu_valid = 0; ld_valid = 0;
    chk("pre_rst_ld_ready", 32'(ld_ready), 0);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_w_en", 32'(w_en), 0);
    chk("async_rst_addr_c", 32'(addr_c), 0);
    chk("async_rst_data_c", 32'(data_c), 0);
    chk("async_rst_ld_ready", 32'(ld_ready), 1);
    chk("async_rst_busy", 32'(busy), 0);
    @(posedge clk); #3 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("post_rst_no_write%0d", i), 32'(w_en), 0);
    end

    // Randomized mixed traffic; ALU data tagged bit15=0, load data bit15=1
    for (int i = 0; i < 400; i++) begin
      alu_valid = 1'($urandom_range(0, 1));
      alu_addr  = 4'($urandom_range(0, 15));
      alu_data  = {1'b0, 15'($urandom)};
      ld_valid  = 1'($urandom_range(0, 2) == 0);
      ld_addr   = 4'($urandom_range(0, 15));
      ld_data   = {1'b1, 15'($urandom)};
      #1;
      if (alu_valid && alu_ready) alu_q.push_back('{alu_addr, alu_data});
      if (ld_valid && ld_ready)   ld_q.push_back('{ld_addr, ld_data});
      @(posedge clk); #1;
      sb_check();
    end
    alu_valid = 0; ld_valid = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      sb_check();
    end
    chk("drain_ld_q_empty", 32'(ld_q.size()), 0);
    chk("drain_alu_q_empty", 32'(alu_q.size()), 0);
    chk("drain_busy", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_writeback_arbiter.md
Name: regfile_writeback_arbiter

Overview:
Write-side driver for the 16-entry processor register file: owns the single write port (w_en, addr_c, data_c). Merges results from the ALU and the load unit, one register write per cycle. Load results are buffered in a small FIFO. A starvation counter guarantees loads retire under continuous ALU traffic.

Parameters:
ADDR_SIZE, 4, register address width (16 registers)
DATA_W, 16, register data width
LD_DEPTH, 2, load FIFO entries (power of two, >=2)
STARVE_MAX, 3, consecutive ALU grants allowed while a load waits

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
alu_valid  in  1  ALU result available
alu_ready  out  1  ALU result accepted this cycle (combinational)
alu_addr  in  ADDR_SIZE  ALU destination register
alu_data  in  DATA_W  ALU result
ld_valid  in  1  load result available
ld_ready  out  1  load FIFO can accept (combinational)
ld_addr  in  ADDR_SIZE  load destination register
ld_data  in  DATA_W  load data
w_en  out  1  register file write enable (registered)
addr_c  out  ADDR_SIZE  register file write address (registered)
data_c  out  DATA_W  register file write data (registered)
busy  out  1  FIFO non-empty or w_en high

Behaviour:
- Reset (rst low, async): FIFO empty (pointers 0, count 0), starve_cnt 0, w_en 0, addr_c 0, data_c 0. Any in-flight FIFO content is discarded. Reset takes effect immediately, not at the next edge.
- Load FIFO:
  - Push on ld_valid && ld_ready.
  - ld_ready = (count != LD_DEPTH). A push is refused when full, even in a cycle that also pops.
  - Pointers wrap modulo LD_DEPTH. Count width is clog2(LD_DEPTH)+1.
- Grant, evaluated each cycle (combinational):
  - ld_pending = count != 0.
  - force_ld = ld_pending && (starve_cnt == STARVE_MAX).
  - grant_ld = ld_pending && (force_ld || !alu_valid).
  - grant_alu = alu_valid && !force_ld.
  - alu_ready = !force_ld. This is independent of alu_valid; no handshake occurs without alu_valid.
- Write register, updated at the clock edge:
  - On grant_alu: w_en 1, addr_c = alu_addr, data_c = alu_data.
  - On grant_ld: w_en 1, addr_c/data_c = FIFO head, then pop.
  - Otherwise: w_en 0; addr_c/data_c hold their previous values.
- Latency:
  - ALU result appears on the write port 1 cycle after acceptance.
  - A load appears no earlier than 2 cycles after push; a push never bypasses the FIFO.
- starve_cnt:
  - 0 when FIFO empty or on grant_ld.
  - Increments on grant_alu while ld_pending; saturates at STARVE_MAX.
- Simultaneous push into an empty FIFO and ALU grant: the ALU writes; starve_cnt stays 0 this cycle (ld_pending was 0).
- Same destination from both sources: the write order is the grant order. The later write wins in the register file; no merging.
- busy = ld_pending || w_en.

Optional Feature:
WB_BYPASS_EN
- Defined:
  - Adds inputs byp_addr_a and byp_addr_b (ADDR_SIZE each).
  - Adds outputs byp_hit_a and byp_hit_b (1 each) and byp_data (DATA_W).
  - byp_hit_x = w_en && (addr_c == byp_addr_x); byp_data = data_c.
  - All combinational from registered state. The decode stage uses this to forward a write landing in the same cycle as its register file read.
- Undefined: these ports do not exist. Write behaviour is identical in both builds.

Test Plan:
- Reset: assert rst low mid-stream with 2 loads queued -> w_en=0, addr_c=0, data_c=0, ld_ready=1, busy=0 immediately; queued loads never written after release.
- ALU only: alu_valid with addr 4'h3, data 16'hBEEF -> next cycle w_en=1, addr_c=3, data_c=BEEF; following cycle w_en=0 when alu_valid is low.
- Load only: push (4'hA, 16'h1234) -> w_en=1, addr_c=A, data_c=1234 exactly 2 cycles after the push edge; then push 3 back-to-back -> third push sees ld_ready=0 when LD_DEPTH=2 and no pop has yet occurred.
- Starvation: alu_valid held high continuously, 1 load queued, STARVE_MAX=3 -> 3 ALU writes, then alu_ready=0 for one cycle and the load is written, then ALU writes resume.
- Same-destination ordering: ALU r5=16'h0001 and load r5=16'h0002 presented in the same cycle -> ALU write first, load write next; final r5=0002.
- WB_BYPASS_EN: w_en=1, addr_c=7, data_c=16'hCAFE, byp_addr_a=7, byp_addr_b=6 -> byp_hit_a=1, byp_hit_b=0, byp_data=CAFE; with the macro undefined, the design elaborates without these ports.
